// File: rtl/sonic_cmd_pkg.sv
// Shared definitions for the SoNIC command queue register block:
// register map, soft-reset key, command record layout and STATUS packing.
package sonic_cmd_pkg;

   // Register offsets on the PIO register bus
   localparam logic [7:0] REG_CMD_TYPE = 8'h00;
   localparam logic [7:0] REG_PARAM0   = 8'h01;
   localparam logic [7:0] REG_PARAM1   = 8'h02;
   localparam logic [7:0] REG_PARAM2   = 8'h03;
   localparam logic [7:0] REG_RESP_HI  = 8'h04;
   localparam logic [7:0] REG_RESP_LO  = 8'h05;
   localparam logic [7:0] REG_STATUS   = 8'h06;
   localparam logic [7:0] REG_DONE_CNT = 8'h07;

   // A CMD_TYPE write carrying this low half is a soft reset, not a command
   localparam logic [15:0] SOFT_RST_KEY = 16'hFFFF;

   // STATUS layout: {overflow, init, 14'b0, count[15:0]}
   localparam int STAT_OVF_BIT  = 31;
   localparam int STAT_INIT_BIT = 30;
   localparam int STAT_CNT_W    = 16;

   // One queued command; field order matches {type, p0, p1, p2, resp_hi, resp_lo}
   typedef struct packed {
      logic [31:0] cmd_type;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [63:0] base_rc;
   } sonic_cmd_t;

   function automatic logic [31:0] pack_status(input logic ovf, input logic init_flag,
                                               input logic [STAT_CNT_W-1:0] cnt);
      logic [31:0] v;
      v = '0;
      v[STAT_OVF_BIT]  = ovf;
      v[STAT_INIT_BIT] = init_flag;
      v[STAT_CNT_W-1:0] = cnt;
      return v;
   endfunction

endpackage

// File: rtl/sonic_cmd_queue_reg_fifo.sv
// Show-ahead command FIFO. The head entry is presented combinationally and
// reads as all-zero while empty. A push into a full FIFO is accepted only
// when a pop happens on the same edge; otherwise it is dropped and flagged.
// Flush empties the FIFO and overrides any push or pop on that edge.
module sonic_cmd_fifo
   import sonic_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     rstn,
   input  logic                     i_push,
   input  sonic_cmd_t               i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output sonic_cmd_t               o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_push_ok,
   output logic                     o_drop
);

   localparam int PTR_W = $clog2(DEPTH);

   sonic_cmd_t         r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;

   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign w_pop_ok  = i_pop && !w_empty && !i_flush;
   assign w_push_ok = i_push && !i_flush && (!w_full || w_pop_ok);

   assign o_empty   = w_empty;
   assign o_full    = w_full;
   assign o_count   = r_count;
   assign o_push_ok = w_push_ok;
   assign o_drop    = i_push && !i_flush && w_full && !w_pop_ok;
   assign o_head    = w_empty ? '0 : r_mem[r_rd_ptr];

   // Storage array: written at the tail on every accepted push
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sonic_cmd_queue_reg.sv
// SoNIC command register block. Host writes go through one input register
// (stage R) and all decode works on that stage. A CMD_TYPE write rings the
// doorbell and pushes the staged record into the command FIFO; the key value
// 0xFFFF in the low half instead soft-resets the block.
// Consumer handshake: the head is transferred on any clk_in edge where
// cmd_valid && cmd_ready; cmd_valid never depends on cmd_ready, and
// cmd_ready while cmd_valid is low has no effect.
module sonic_cmd_queue_reg
   import sonic_cmd_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk_in,
   input  logic              rstn,
   input  logic              prg_wrena,
   input  logic [31:0]       prg_wrdata,
   input  logic [ADDR_W-1:0] prg_addr,
   output logic [31:0]       prg_rddata,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [31:0]       cmd_type,
   output logic [31:0]       cmd_param0,
   output logic [31:0]       cmd_param1,
   output logic [31:0]       cmd_param2,
   output logic [63:0]       cmd_base_rc,
   output logic              cmd_3dw_rcadd,
   input  logic              cmd_done,
   output logic              init,
   output logic              cmd_overflow
);

   localparam int FCNT_W = $clog2(DEPTH) + 1;

   // Stage R
   logic              r_wrena;
   logic [31:0]       r_wrdata;
   logic [ADDR_W-1:0] r_addr;

   // Staging and status state
   logic [31:0]       r_p0;
   logic [31:0]       r_p1;
   logic [31:0]       r_p2;
   logic [31:0]       r_resp_hi;
   logic [31:0]       r_resp_lo;
   logic [31:0]       r_last_type;
   logic              r_overflow;
   logic              r_init;
   logic [CNT_W-1:0]  r_done_cnt;
   logic [31:0]       r_rddata;

   logic              w_wr_type;
   logic              w_doorbell;
   logic              w_soft_rst;
   sonic_cmd_t        w_push_data;
   sonic_cmd_t        w_head;
   logic              w_empty;
   logic              w_full;
   logic [FCNT_W-1:0] w_count;
   logic              w_push_ok;
   logic              w_drop;
   logic [31:0]       w_rd_mux;

   assign w_wr_type  = r_wrena && (r_addr == ADDR_W'(REG_CMD_TYPE));
   assign w_doorbell = w_wr_type && (r_wrdata[15:0] != SOFT_RST_KEY);
   assign w_soft_rst = w_wr_type && (r_wrdata[15:0] == SOFT_RST_KEY);
   assign w_push_data = {r_wrdata, r_p0, r_p1, r_p2, r_resp_hi, r_resp_lo};

   // Register the host bus once; all decode happens on this stage
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         r_wrena  <= 1'b0;
         r_wrdata <= '0;
         r_addr   <= '0;
      end else begin
         r_wrena  <= prg_wrena;
         r_wrdata <= prg_wrdata;
         r_addr   <= prg_addr;
      end
   end

   sonic_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_in    (clk_in),
      .rstn      (rstn),
      .i_push    (w_doorbell),
      .i_data    (w_push_data),
      .i_pop     (cmd_ready),
      .i_flush   (w_soft_rst),
      .o_head    (w_head),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_count   (w_count),
      .o_push_ok (w_push_ok),
      .o_drop    (w_drop)
   );

   // Staging registers; retained across pushes, cleared by soft reset
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         r_p0      <= '0;
         r_p1      <= '0;
         r_p2      <= '0;
         r_resp_hi <= '0;
         r_resp_lo <= '0;
      end else if (w_soft_rst) begin
         r_p0      <= '0;
         r_p1      <= '0;
         r_p2      <= '0;
         r_resp_hi <= '0;
         r_resp_lo <= '0;
      end else if (r_wrena) begin
         if (r_addr == ADDR_W'(REG_PARAM0))  r_p0      <= r_wrdata;
         if (r_addr == ADDR_W'(REG_PARAM1))  r_p1      <= r_wrdata;
         if (r_addr == ADDR_W'(REG_PARAM2))  r_p2      <= r_wrdata;
         if (r_addr == ADDR_W'(REG_RESP_HI)) r_resp_hi <= r_wrdata;
         if (r_addr == ADDR_W'(REG_RESP_LO)) r_resp_lo <= r_wrdata;
      end
   end

   // Remember the most recent doorbell value for CMD_TYPE readback
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn)           r_last_type <= '0;
      else if (w_doorbell) r_last_type <= r_wrdata;
   end

   // Sticky overflow, init flag and completion counter
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
         r_overflow <= 1'b0;
         r_init     <= 1'b1;
         r_done_cnt <= '0;
      end else if (w_soft_rst) begin
         r_overflow <= 1'b0;
         r_init     <= 1'b1;
         r_done_cnt <= '0;
      end else begin
         if (w_drop)
            r_overflow <= 1'b1;
         else if (r_wrena && (r_addr == ADDR_W'(REG_STATUS)) && r_wrdata[STAT_OVF_BIT])
            r_overflow <= 1'b0;
         if (w_push_ok) r_init <= 1'b0;
         if (cmd_done)  r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
   end

   // Read mux on the stage-R address; unmapped offsets read zero
   always_comb begin
      w_rd_mux = '0;
      case (r_addr)
         ADDR_W'(REG_CMD_TYPE): w_rd_mux = r_last_type;
         ADDR_W'(REG_PARAM0):   w_rd_mux = r_p0;
         ADDR_W'(REG_PARAM1):   w_rd_mux = r_p1;
         ADDR_W'(REG_PARAM2):   w_rd_mux = r_p2;
         ADDR_W'(REG_RESP_HI):  w_rd_mux = r_resp_hi;
         ADDR_W'(REG_RESP_LO):  w_rd_mux = r_resp_lo;
         ADDR_W'(REG_STATUS):   w_rd_mux = pack_status(r_overflow, r_init, STAT_CNT_W'(w_count));
         ADDR_W'(REG_DONE_CNT): w_rd_mux = 32'(r_done_cnt);
         default:               w_rd_mux = '0;
      endcase
   end

   // Registered read data, refreshed every clock
   always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) r_rddata <= '0;
      else       r_rddata <= w_rd_mux;
   end

   assign prg_rddata    = r_rddata;
   assign cmd_valid     = !w_empty;
   assign cmd_type      = w_head.cmd_type;
   assign cmd_param0    = w_head.p0;
   assign cmd_param1    = w_head.p1;
   assign cmd_param2    = w_head.p2;
   assign cmd_base_rc   = w_head.base_rc;
   assign cmd_3dw_rcadd = (w_head.base_rc[63:32] == 32'd0);
   assign init          = r_init;
   assign cmd_overflow  = r_overflow;

   logic w_unused;
   assign w_unused = w_full;

endmodule

// File: tb/tb_sonic_cmd_queue_reg.sv
// Directed bench for sonic_cmd_queue_reg: register staging, doorbell pushes,
// overflow, full-with-pop, soft reset, done counter, reads and async reset.
module tb_sonic_cmd_queue_reg;

   logic        clk_in;
   logic        rstn;
   logic        prg_wrena;
   logic [31:0] prg_wrdata;
   logic [7:0]  prg_addr;
   logic [31:0] prg_rddata;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_type;
   logic [31:0] cmd_param0;
   logic [31:0] cmd_param1;
   logic [31:0] cmd_param2;
   logic [63:0] cmd_base_rc;
   logic        cmd_3dw_rcadd;
   logic        cmd_done;
   logic        init;
   logic        cmd_overflow;

   int n_cmp;
   int n_err;
   logic [31:0] rd;

   sonic_cmd_queue_reg dut (
      .clk_in        (clk_in),
      .rstn          (rstn),
      .prg_wrena     (prg_wrena),
      .prg_wrdata    (prg_wrdata),
      .prg_addr      (prg_addr),
      .prg_rddata    (prg_rddata),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_type      (cmd_type),
      .cmd_param0    (cmd_param0),
      .cmd_param1    (cmd_param1),
      .cmd_param2    (cmd_param2),
      .cmd_base_rc   (cmd_base_rc),
      .cmd_3dw_rcadd (cmd_3dw_rcadd),
      .cmd_done      (cmd_done),
      .init          (init),
      .cmd_overflow  (cmd_overflow)
   );

   // Clock
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One-cycle register write; takes effect one edge after this call returns
   task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
      prg_wrena  = 1'b1;
      prg_addr   = a;
      prg_wrdata = d;
      tick();
      prg_wrena  = 1'b0;
      prg_wrdata = '0;
   endtask

   // Register read with its two-clock latency
   task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
      prg_addr = a;
      tick();
      tick();
      d = prg_rddata;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn = 1'b0;
      prg_wrena = 1'b0;
      prg_wrdata = '0;
      prg_addr = '0;
      cmd_ready = 1'b0;
      cmd_done = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_valid", cmd_valid, 0);
      chk("rst_type", cmd_type, 0);
      chk("rst_base", cmd_base_rc, 0);
      chk("rst_3dw", cmd_3dw_rcadd, 1);
      chk("rst_init", init, 1);
      chk("rst_ovf", cmd_overflow, 0);
      chk("rst_rddata", prg_rddata, 0);
      rstn = 1'b1;
      tick();

      // First command
      reg_wr(8'h01, 32'h11);
      reg_wr(8'h02, 32'h22);
      reg_wr(8'h03, 32'h33);
      reg_wr(8'h04, 32'h0);
      reg_wr(8'h05, 32'h1000);
      reg_wr(8'h00, 32'h5);
      chk("db_valid_early", cmd_valid, 0);
      tick();
      chk("db_valid", cmd_valid, 1);
      chk("db_type", cmd_type, 32'h5);
      chk("db_p0", cmd_param0, 32'h11);
      chk("db_p1", cmd_param1, 32'h22);
      chk("db_p2", cmd_param2, 32'h33);
      chk("db_base", cmd_base_rc, 64'h1000);
      chk("db_3dw", cmd_3dw_rcadd, 1);
      chk("db_init", init, 0);
      reg_rd(8'h00, rd);
      chk("rd_cmd_type", rd, 32'h5);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("pop1_valid", cmd_valid, 0);

      // Overflow: DEPTH+1 doorbells with no pops
      for (int i = 1; i <= 5; i++) reg_wr(8'h00, i);
      tick();
      chk("ovf_flag", cmd_overflow, 1);
      reg_rd(8'h06, rd);
      chk("ovf_status", rd, 32'h8000_0004);
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("ovf_head", cmd_type, i);
         tick();
      end
      cmd_ready = 1'b0;
      chk("ovf_drain_valid", cmd_valid, 0);
      reg_wr(8'h06, 32'h8000_0000);
      tick();
      chk("ovf_clear", cmd_overflow, 0);

      // Full FIFO with push and pop on the same edge
      for (int i = 0; i < 4; i++) reg_wr(8'h00, 32'h10 + i);
      tick();
      reg_wr(8'h00, 32'h14);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("fp_ovf", cmd_overflow, 0);
      chk("fp_head", cmd_type, 32'h11);
      reg_rd(8'h06, rd);
      chk("fp_status", rd, 32'h0000_0004);
      cmd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("fp_order", cmd_type, 32'h10 + i);
         tick();
      end
      cmd_ready = 1'b0;
      chk("fp_empty", cmd_valid, 0);

      // Soft reset with 3 queued and done counter 7 (done also on the reset edge)
      for (int i = 1; i <= 3; i++) reg_wr(8'h00, 32'h20 + i);
      tick();
      cmd_done = 1'b1;
      repeat (7) tick();
      cmd_done = 1'b0;
      reg_rd(8'h07, rd);
      chk("done7", rd, 7);
      reg_rd(8'h06, rd);
      chk("sr_pre_status", rd, 32'h0000_0003);
      reg_rd(8'h01, rd);
      chk("sr_pre_p0", rd, 32'h11);
      reg_wr(8'h00, 32'h0000_FFFF);
      cmd_done = 1'b1;
      cmd_ready = 1'b1;
      tick();
      cmd_done = 1'b0;
      cmd_ready = 1'b0;
      chk("sr_valid", cmd_valid, 0);
      chk("sr_init", init, 1);
      chk("sr_type", cmd_type, 0);
      reg_rd(8'h07, rd);
      chk("sr_done", rd, 0);
      reg_rd(8'h06, rd);
      chk("sr_status", rd, 32'h4000_0000);
      reg_rd(8'h01, rd);
      chk("sr_p0", rd, 0);

      // Done counter, unmapped read and read latency
      cmd_done = 1'b1;
      repeat (3) tick();
      cmd_done = 1'b0;
      reg_rd(8'h20, rd);
      chk("rd_unmapped", rd, 0);
      prg_addr = 8'h07;
      tick();
      chk("lat_1clk", prg_rddata, 0);
      tick();
      chk("lat_2clk", prg_rddata, 3);

      // Asynchronous reset mid-burst
      reg_wr(8'h02, 32'hAB);
      reg_wr(8'h00, 32'h31);
      reg_wr(8'h00, 32'h32);
      tick();
      chk("ar_pre_valid", cmd_valid, 1);
      chk("ar_pre_type", cmd_type, 32'h31);
      prg_wrena = 1'b1;
      prg_addr = 8'h00;
      prg_wrdata = 32'h33;
      @(negedge clk_in);
      rstn = 1'b0;
      #1;
      chk("ar_valid", cmd_valid, 0);
      chk("ar_type", cmd_type, 0);
      chk("ar_p1", cmd_param1, 0);
      chk("ar_3dw", cmd_3dw_rcadd, 1);
      chk("ar_init", init, 1);
      chk("ar_rddata", prg_rddata, 0);
      prg_wrena = 1'b0;
      prg_wrdata = '0;
      tick();
      tick();
      rstn = 1'b1;
      tick();
      reg_wr(8'h01, 32'h55);
      reg_wr(8'h00, 32'h7);
      tick();
      chk("post_valid", cmd_valid, 1);
      chk("post_type", cmd_type, 32'h7);
      chk("post_p0", cmd_param0, 32'h55);
      chk("post_p1", cmd_param1, 0);
      chk("post_init", init, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
